// File: rtl/font_rom_arbiter.sv
// Round-robin share of one font ROM read port among NUM_REQ renderers; response returns 2 cycles after req&gnt.
// No backpressure: one grant per cycle, responses cannot stall, requesters wait for gnt while holding req/addr.
module font_rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_dout,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data
);

  typedef struct packed {
    logic                vld;
    logic [ID_WIDTH-1:0] id;
  } stage_t;

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [ID_WIDTH-1:0]   ptr_nxt;
  logic                  xfer;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  stage_t                s1;
  stage_t                s2;

  // Search upward from ptr; the index is folded back below NUM_REQ so
  // non-power-of-two builds never select a nonexistent requester.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    xfer    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!xfer && req[idx]) begin
        xfer    = 1'b1;
        gnt_idx = ID_WIDTH'(idx);
      end
    end
    if (xfer) gnt[gnt_idx] = 1'b1;
  end

  assign gnt_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign ptr_nxt  = (gnt_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_idx + ID_WIDTH'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      rom_addr <= '0;
      s1       <= '0;
      s2       <= '0;
    end else begin
      if (xfer) begin
        ptr      <= ptr_nxt;
        rom_addr <= gnt_addr;
      end
      s1.vld <= xfer;
      s1.id  <= xfer ? gnt_idx : s1.id;
      s2     <= s1;
    end
  end

  // ROM data is already one cycle behind rom_addr, which lines up with s2.
  assign rsp_valid = s2.vld;
  assign rsp_id    = s2.id;
  assign rsp_data  = rom_dout;

endmodule

// File: doc/font_rom_arbiter.md
# font_rom_arbiter

Round-robin arbiter that shares one synchronous font ROM (1-cycle registered read, `addr` in, `dout` out) between several digit renderers in the VGA clock pixel pipeline. Each renderer issues glyph-row reads through a req/gnt handshake. The arbiter drives the single ROM address port and returns each read's data tagged with the requester ID a fixed two cycles after the handshake. It sits between the hour/minute/second digit renderers and the font ROM instance.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `ADDR_WIDTH`, 6: ROM address width; matches the ROM `addr_width`.
- `DATA_WIDTH`, 3: ROM data width; matches the ROM `data_width`.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: width of the response tag.

- `clk`  in  1  system (pixel) clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester read request; bit i belongs to requester i.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `gnt`  out  NUM_REQ  one-hot grant; combinational from `req` and the RR pointer.
- `rom_addr`  out  ADDR_WIDTH  registered address to the ROM `addr`.
- `rom_dout`  in  DATA_WIDTH  ROM `dout`.
- `rsp_valid`  out  1  response strobe, one cycle per accepted read.
- `rsp_id`  out  ID_WIDTH  requester index the response belongs to.
- `rsp_data`  out  DATA_WIDTH  read data; equals `rom_dout`, meaningful only when `rsp_valid`=1.

## Operation
- **Handshake**
  - A transfer occurs in any cycle where `req[i]` and `gnt[i]` are both 1.
  - The requester holds `req[i]` and its address stable until it sees `gnt[i]`.
  - It may drop or re-present a new address on the next cycle.
- **Grant selection**
  - `gnt` is the first set bit of `req`, searching upward from pointer `ptr` with wrap-around modulo NUM_REQ.
  - `gnt` is all-zero when `req`=0.
  - At most one grant per cycle. Throughput is one read per cycle.
- **Pointer update**
  - On a transfer to requester i, `ptr` <= (i+1) mod NUM_REQ.
  - With no transfer, `ptr` holds.
  - Reset value of `ptr` is 0, so requester 0 wins the first contention.
  - Fairness: a continuously asserted requester is granted within NUM_REQ cycles.
- **Address stage**
  - On a transfer, `rom_addr` <= the granted address.
  - With no transfer, `rom_addr` holds its value; no spurious toggling.
- **Response pipeline** (two register stages, valid+id each)
  - s1_valid/s1_id load on the transfer edge.
  - s2 (`rsp_valid`/`rsp_id`) loads from s1 on the next edge.
  - `rsp_data` = `rom_dout`, passed through combinationally.
- **Simultaneous events**
  - A new transfer in the same cycle a response is presented is allowed; no bubbles.
  - Responses return in grant order.
- **Width rules**
  - `rsp_id` is the binary index of the granted bit, zero-extended into ID_WIDTH.
  - For NUM_REQ not a power of two, `ptr` wraps from NUM_REQ-1 to 0; values ≥ NUM_REQ never occur.
- **Reset**
  - Asserting `reset_n`=0 at any time clears `ptr`, `rom_addr`, s1 and s2 immediately.
  - In-flight reads are discarded with no response.
  - `gnt` follows `req` combinationally even during reset. Transfers made while reset is asserted are lost; requesters must not rely on them.

## Timing
- Reset values: `rom_addr`=0, `rsp_valid`=0, `rsp_id`=0, `ptr`=0. `gnt` is combinational with no reset value.
- Transfer in cycle N:
  - `rom_addr` is valid in cycle N+1.
  - The ROM registers it at the end of N+1.
  - `rsp_valid`=1 with matching `rsp_id`/`rsp_data` in cycle N+2.
- Fixed latency of 2 cycles from handshake to response, independent of load.
- Back-to-back transfers in N, N+1, N+2 produce responses in N+2, N+3, N+4.
- Reset deassertion: the first transfer is possible in the first cycle after `reset_n` rises; its response appears 2 cycles later.

## Test plan
- **Reset values:** hold `reset_n`=0 → `rom_addr`=0, `rsp_valid`=0, `rsp_id`=0; release with `req`=0 → outputs unchanged.
- **Single read:** `req`=0001, addr0=6'd13, ROM preloaded with mem[13]=3'b101 → `gnt`=0001 in cycle N; `rom_addr`=13 in N+1; `rsp_valid`=1, `rsp_id`=0, `rsp_data`=101 in N+2 only.
- **Full contention:** `req`=1111 held for 8 cycles after reset → grant order 0,1,2,3,0,1,2,3; `rsp_valid` continuously 1 from cycle 2 with `rsp_id` in the same order.
- **Pointer wrap and skip:** after a grant to 3, `req`=1010 → grant to 1, then 3, then 1; with `req`=0000 for 5 cycles in between, the pointer holds and requester 1 is next.
- **Reset mid-flight:** transfers in N and N+1, `reset_n` pulsed low in N+1 → no `rsp_valid` in N+2/N+3; `ptr` back to 0; next `req`=1111 grants requester 0.
- **NUM_REQ=3 build:** `req`=111 for 6 cycles → grants 0,1,2,0,1,2; `rsp_id` never equals 3.
